// File: rtl/gpio_in_filter.sv
// GPIO pad input receiver: per-bit two-flop synchroniser, optional stable-count
// glitch filter, edge detection and sticky W1C edge interrupts.
module gpio_in_filter #(
    parameter int N_GPIO        = 32,
    parameter int FILTER_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_GPIO-1:0] gpio_i,
    input  logic [N_GPIO-1:0] filter_en_i,
    input  logic [N_GPIO-1:0] intr_rise_en_i,
    input  logic [N_GPIO-1:0] intr_fall_en_i,
    input  logic [N_GPIO-1:0] intr_clear_i,
    output logic [N_GPIO-1:0] data_in_o,
    output logic [N_GPIO-1:0] intr_state_o,
    output logic              intr_o
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [N_GPIO-1:0] sync1_q, sync2_q;
    logic [N_GPIO-1:0] data_q, data_d;
    logic [N_GPIO-1:0] intr_q, intr_d;
    logic [N_GPIO-1:0] rise, fall;
    logic [CW-1:0]     cnt_q [N_GPIO];
    logic [CW-1:0]     cnt_d [N_GPIO];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

    // A disabled filter passes the synchronised value straight through and
    // keeps its counter at zero, so re-enabling always requalifies from 0.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        for (int unsigned i = 0; i < N_GPIO; i++) begin
            if (!filter_en_i[i]) begin
                data_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else if (sync2_q[i] == data_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                data_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign rise = data_d & ~data_q;
    assign fall = ~data_d & data_q;

    // Setting has priority over a coincident clear.
    assign intr_d = (intr_q & ~intr_clear_i)
                  | (rise & intr_rise_en_i)
                  | (fall & intr_fall_en_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            intr_q <= '0;
            cnt_q  <= '{default: '0};
        end else begin
            data_q <= data_d;
            intr_q <= intr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_in_o    = data_q;
    assign intr_state_o = intr_q;
    assign intr_o       = |intr_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Scoreboard bench for gpio_in_filter: directed stimulus pushes timed expectations,
// a negedge monitor pops and compares them at the edge they fall due.
module tb_gpio_in_filter;

    localparam int N = 32;
    localparam int F = 16;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [N-1:0] gpio_i, filter_en_i, intr_rise_en_i, intr_fall_en_i, intr_clear_i;
    logic [N-1:0] data_in_o, intr_state_o;
    logic         intr_o;

    gpio_in_filter #(.N_GPIO(N), .FILTER_CYCLES(F)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .gpio_i         (gpio_i),
        .filter_en_i    (filter_en_i),
        .intr_rise_en_i (intr_rise_en_i),
        .intr_fall_en_i (intr_fall_en_i),
        .intr_clear_i   (intr_clear_i),
        .data_in_o      (data_in_o),
        .intr_state_o   (intr_state_o),
        .intr_o         (intr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          e;
        string       tag;
        logic [31:0] mask;
        logic [31:0] data;
        logic [31:0] intr;
        bit          chk_irq;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n  = 0;
    int   n_err   = 0;
    int   n_check = 0;

    always @(posedge clk_i) edge_n <= edge_n + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_check++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic push(input int e, input string tag, input logic [31:0] mask,
                        input logic [31:0] data, input logic [31:0] intr,
                        input bit chk_irq, input logic irq);
        exp_t x;
        x.e = e; x.tag = tag; x.mask = mask; x.data = data; x.intr = intr;
        x.chk_irq = chk_irq; x.irq = irq;
        exp_q.push_back(x);
    endtask

    always @(negedge clk_i) begin
        while (exp_q.size() > 0 && exp_q[0].e <= edge_n) begin
            exp_t x;
            x = exp_q.pop_front();
            if (x.e < edge_n)
                check_eq({x.tag, "_missed_edge"}, 32'(edge_n), 32'(x.e));
            check_eq({x.tag, "_data"}, data_in_o & x.mask, x.data & x.mask);
            check_eq({x.tag, "_intr"}, intr_state_o & x.mask, x.intr & x.mask);
            if (x.chk_irq)
                check_eq({x.tag, "_irq"}, {31'b0, intr_o}, {31'b0, x.irq});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    int t;

    initial begin
        rst_ni = 1'b0;
        gpio_i = '0; filter_en_i = '0; intr_rise_en_i = '0;
        intr_fall_en_i = '0; intr_clear_i = '0;
        tick(3);

        // Reset release with quiet pads: everything stays zero.
        rst_ni = 1'b1;
        t = edge_n;
        for (int k = 1; k <= 5; k++) push(t + k, "rst_idle", '1, '0, '0, 1, 1'b0);
        tick(6);

        // Unfiltered rise on bit 3, then W1C clear.
        intr_rise_en_i[3] = 1'b1;
        gpio_i[3] = 1'b1;
        t = edge_n;
        push(t + 2, "b3_lat_before", 32'h8, 32'h0, 32'h0, 1, 1'b0);
        push(t + 3, "b3_rise",       32'h8, 32'h8, 32'h8, 1, 1'b1);
        tick(3);
        intr_clear_i[3] = 1'b1;
        push(t + 4, "b3_clear",      32'h8, 32'h8, 32'h0, 1, 1'b0);
        tick(1);
        intr_clear_i[3] = 1'b0;
        push(t + 5, "b3_cleared",    32'h8, 32'h8, 32'h0, 1, 1'b0);
        tick(2);

        // Filtered bit 5: a 15-sample glitch is rejected.
        filter_en_i[5] = 1'b1;
        intr_rise_en_i[5] = 1'b1;
        gpio_i[5] = 1'b1;
        t = edge_n;
        push(t + 3,  "b5_glitch_a", 32'h20, 32'h0, 32'h0, 1, 1'b0);
        push(t + 10, "b5_glitch_b", 32'h20, 32'h0, 32'h0, 1, 1'b0);
        push(t + 17, "b5_glitch_c", 32'h20, 32'h0, 32'h0, 1, 1'b0);
        push(t + 18, "b5_glitch_d", 32'h20, 32'h0, 32'h0, 1, 1'b0);
        push(t + 20, "b5_glitch_e", 32'h20, 32'h0, 32'h0, 1, 1'b0);
        tick(15);
        gpio_i[5] = 1'b0;
        tick(5);

        // Filtered bit 5: 16 stable samples qualify at k+17.
        gpio_i[5] = 1'b1;
        t = edge_n;
        push(t + 17, "b5_qual_before", 32'h20, 32'h0,  32'h0,  1, 1'b0);
        push(t + 18, "b5_qual",        32'h20, 32'h20, 32'h20, 1, 1'b1);
        tick(18);
        intr_clear_i[5] = 1'b1;
        push(t + 19, "b5_clear", 32'h20, 32'h20, 32'h0, 1, 1'b0);
        tick(1);
        intr_clear_i[5] = 1'b0;
        tick(2);

        // Bit 5 mid-count (10): disabling passes the value through, and after
        // re-enabling a fresh transition needs a full 16 samples.
        gpio_i[5] = 1'b0;
        t = edge_n;
        push(t + 12, "b5_midcount",  32'h20, 32'h20, 32'h0, 0, 1'b0);
        push(t + 13, "b5_filt_off",  32'h20, 32'h0,  32'h0, 1, 1'b0);
        push(t + 30, "b5_requal_pre", 32'h20, 32'h0,  32'h0,  1, 1'b0);
        push(t + 31, "b5_requal",    32'h20, 32'h20, 32'h20, 1, 1'b1);
        push(t + 32, "b5_requal_clr", 32'h20, 32'h20, 32'h0, 1, 1'b0);
        tick(12);
        filter_en_i[5] = 1'b0;
        tick(1);
        filter_en_i[5] = 1'b1;
        gpio_i[5] = 1'b1;
        tick(18);
        intr_clear_i[5] = 1'b1;
        tick(1);
        intr_clear_i[5] = 1'b0;
        tick(2);

        // Bit 0 falling edge: set wins over a coincident clear.
        intr_fall_en_i[0] = 1'b1;
        gpio_i[0] = 1'b1;
        t = edge_n;
        push(t + 3,  "b0_high",      32'h1, 32'h1, 32'h0, 1, 1'b0);
        push(t + 6,  "b0_fall",      32'h1, 32'h0, 32'h1, 1, 1'b1);
        push(t + 9,  "b0_high2",     32'h1, 32'h1, 32'h1, 1, 1'b1);
        push(t + 12, "b0_set_wins",  32'h1, 32'h0, 32'h1, 1, 1'b1);
        push(t + 13, "b0_held",      32'h1, 32'h0, 32'h1, 1, 1'b1);
        push(t + 14, "b0_clear",     32'h1, 32'h0, 32'h0, 1, 1'b0);
        tick(3);
        gpio_i[0] = 1'b0;
        tick(3);
        gpio_i[0] = 1'b1;
        tick(3);
        gpio_i[0] = 1'b0;
        tick(2);
        intr_clear_i[0] = 1'b1;
        tick(1);
        intr_clear_i[0] = 1'b0;
        tick(1);
        intr_clear_i[0] = 1'b1;
        tick(1);
        intr_clear_i[0] = 1'b0;
        tick(2);

        // All bits rise together (bits 3 and 5 were already high).
        filter_en_i = '0;
        intr_rise_en_i = '1;
        intr_fall_en_i = '0;
        gpio_i = '1;
        t = edge_n;
        push(t + 3, "all_rise", '1, '1, 32'hFFFF_FFD7, 1, 1'b1);
        tick(3);

        // Asynchronous reset mid-cycle clears outputs immediately.
        #2 rst_ni = 1'b0;
        #1;
        check_eq("async_rst_data", data_in_o, '0);
        check_eq("async_rst_intr", intr_state_o, '0);
        check_eq("async_rst_irq", {31'b0, intr_o}, 32'h0);
        tick(2);

        // Pads high through reset: rise events appear at edge 3 after release.
        rst_ni = 1'b1;
        t = edge_n;
        push(t + 1, "post_rst_e1", '1, '0, '0, 1, 1'b0);
        push(t + 2, "post_rst_e2", '1, '0, '0, 1, 1'b0);
        push(t + 3, "post_rst_e3", '1, '1, '1, 1, 1'b1);
        tick(4);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick(1);
        check_eq("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_check);
        $finish;
    end

endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
- Device-side receiver for the host-driven GPIO pad bus (gpio_p2d, host to device).
- Per bit, it synchronises the pad input to clk_i and optionally applies a stable-count glitch filter.
- It detects rising and falling edges on the conditioned value.
- Edge events accumulate in sticky, clearable interrupt state bits. The block feeds the GPIO register file and the interrupt aggregator.

Parameters:
N_GPIO, 32, number of GPIO bits
FILTER_CYCLES, 16, consecutive stable synchronised samples required before a filtered bit updates; legal range 1..65535

Ports:
clk_i  input  1  single clock; all logic is in this domain
rst_ni  input  1  reset, asynchronous, active-low
gpio_i  input  N_GPIO  raw pad input from host/pad model; asynchronous to clk_i
filter_en_i  input  N_GPIO  per-bit glitch filter enable
intr_rise_en_i  input  N_GPIO  per-bit rising-edge interrupt enable
intr_fall_en_i  input  N_GPIO  per-bit falling-edge interrupt enable
intr_clear_i  input  N_GPIO  per-bit clear of intr_state_o; single-cycle pulse, W1C semantics
data_in_o  output  N_GPIO  conditioned (synchronised, optionally filtered) input value
intr_state_o  output  N_GPIO  sticky per-bit interrupt state
intr_o  output  1  OR-reduction of intr_state_o

Behaviour:
Reset:
- Async assert clears all state: sync flops, filter counters, data_in_o, intr_state_o; intr_o = 0.
- Deassertion is used synchronously.

Synchroniser:
- Two flop stages per bit: gpio_i -> s1 -> s2. No reset-free flops.

Counter:
- One counter per bit, width $clog2(FILTER_CYCLES+1).

Per-bit update, with v = data_in_o[i]:
- filter_en_i[i]=0: v <= s2; counter held at 0.
- filter_en_i[i]=1 and s2==v: counter <= 0.
- filter_en_i[i]=1, s2!=v, counter < FILTER_CYCLES-1: counter <= counter+1.
- filter_en_i[i]=1, s2!=v, counter == FILTER_CYCLES-1: v <= s2; counter <= 0.
- A glitch shorter than FILTER_CYCLES samples leaves v unchanged and restarts the count.
- FILTER_CYCLES=1 behaves identically to the unfiltered path.

Filter enable changes:
- Toggling filter_en_i mid-count clears the counter.
- Re-enabling restarts qualification from 0.

Latency (gpio_i stable before edge k):
- Unfiltered: data_in_o updates at edge k+2.
- Filtered: data_in_o updates at edge k+1+FILTER_CYCLES.

Edge events (combinational from v_next vs v):
- rise[i] = v_next & ~v
- fall[i] = ~v_next & v

Interrupt state:
- Set at the same edge data_in_o changes: intr_state[i] <= 1 if (rise&intr_rise_en)|(fall&intr_fall_en).
- Else cleared if intr_clear_i[i].
- Set wins over a simultaneous clear.
- Enables gate only setting; disabling an enable does not clear existing state.

Output timing:
- intr_o is combinational OR of registered intr_state_o; no extra latency.

Post-reset behaviour:
- data_in_o resets to 0. A pad held high through reset produces a rise event after reset release, if enabled.

Reset mid-operation:
- In-flight counts and pending edges are discarded.
- The post-release value is requalified from 0.

Bit independence:
- All bits are independent. Simultaneous events on multiple bits are all captured.

Test Plan:
- Reset release, gpio_i=0, filter off -> data_in_o=0, intr_state_o=0, intr_o=0 at every edge.
- Filter off, rise_en[3]=1, gpio_i[3] 0->1 before edge k -> data_in_o[3]=1 and intr_state_o[3]=1 at edge k+2; intr_o=1; intr_clear_i[3] pulse -> intr_state_o[3]=0 next edge.
- filter_en[5]=1, FILTER_CYCLES=16, gpio_i[5] high for 15 cycles then low -> data_in_o[5] stays 0, no interrupt. Then high for 16+ cycles -> data_in_o[5]=1 at edge k+17.
- fall_en[0]=1, state 1, intr_clear_i[0] pulsed on the same edge a new falling edge qualifies -> intr_state_o[0] remains 1.
- Filtered bit mid-count (counter=10): toggle filter_en off then on -> counter restarts; update requires a full 16 further stable samples.
- gpio_i=32'hFFFF_FFFF held through reset, all rise_en=1, filter off -> all intr_state_o bits set at edge 3 after release. Assert rst_ni mid-run -> everything clears immediately (async).
